flex_down_counter: RTL and testbench

// - Parameterised loadable down-counter/timer: the count-down counterpart of the up-counting flex counter.
// - Loads a start value, decrements once per count_enable cycle and flags expiry on reaching zero.
// - Optional auto-reload for periodic tick generation.
// - Feeds timeout, bit-period and delay generators elsewhere in the design.
//

---
 rtl/flex_down_counter_if.sv | 24 ++
 rtl/flex_down_counter.sv | 74 +++++++
 tb/tb_flex_down_counter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/flex_down_counter_if.sv
// rtl/flex_down_counter_if.sv - control/status bundle for the loadable down-counter
interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_value;
  logic                    count_enable;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    zero_flag;
  logic                    done;
  logic                    busy;
  logic                    expired;

  modport master (
    output clear, load, load_value, count_enable,
    input  count_out, zero_flag, done, busy, expired
  );

  modport slave (
    input  clear, load, load_value, count_enable,
    output count_out, zero_flag, done, busy, expired
  );
endinterface

// File: rtl/flex_down_counter.sv
// rtl/flex_down_counter.sv - loadable down-counter/timer with expiry pulse and optional auto-reload
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4,
  parameter bit AUTO_RELOAD  = 1'b0
) (
  input logic                 clk,
  input logic                 n_reset,
  flex_down_counter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  logic [1:0]              state;
  logic [NUM_CNT_BITS-1:0] count;
  logic [NUM_CNT_BITS-1:0] reload_reg;
  logic                    done_r;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= IDLE;
      count      <= CNT_ZERO;
      reload_reg <= CNT_ZERO;
      done_r     <= 1'b0;
    end else if (bus.clear) begin
      state  <= IDLE;
      count  <= CNT_ZERO;
      done_r <= 1'b0;
    end else if (bus.load) begin
      // a load always restarts the run and suppresses any coincident expiry
      reload_reg <= bus.load_value;
      count      <= bus.load_value;
      state      <= (bus.load_value != CNT_ZERO) ? RUN : IDLE;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        RUN: begin
          if (bus.count_enable) begin
            if (count == CNT_ONE) begin
              done_r <= 1'b1;
              if (AUTO_RELOAD) begin
                count <= reload_reg;
              end else begin
                count <= CNT_ZERO;
                state <= EXPIRED;
              end
            end else begin
              count <= count - CNT_ONE;
            end
          end
        end
        IDLE, EXPIRED: begin
          count <= count;
        end
        default: begin
          state <= IDLE;
          count <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.count_out = count;
  assign bus.zero_flag = (count == CNT_ZERO);
  assign bus.done      = done_r;
  assign bus.busy      = (state == RUN);
  assign bus.expired   = (state == EXPIRED);

endmodule

// File: tb/tb_flex_down_counter.sv
// tb/tb_flex_down_counter.sv - directed self-checking bench for flex_down_counter
module tb_flex_down_counter;

  logic clk;
  logic n_reset;
  int   n_checks;
  int   n_fails;

  flex_down_counter_if #(.NUM_CNT_BITS(4)) a_if ();
  flex_down_counter_if #(.NUM_CNT_BITS(4)) b_if ();

  flex_down_counter #(.NUM_CNT_BITS(4), .AUTO_RELOAD(1'b0)) u_dut_a (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (a_if.slave)
  );

  flex_down_counter #(.NUM_CNT_BITS(4), .AUTO_RELOAD(1'b1)) u_dut_b (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int cnt, input int zf, input int dn,
                         input int bsy, input int exp_d);
    check({tag, ".count"},   a_if.count_out, cnt);
    check({tag, ".zero"},    a_if.zero_flag, zf);
    check({tag, ".done"},    a_if.done,      dn);
    check({tag, ".busy"},    a_if.busy,      bsy);
    check({tag, ".expired"}, a_if.expired,   exp_d);
  endtask

  initial begin
    int hold_en[4]  = '{1, 0, 0, 1};
    int hold_exp[4] = '{6, 6, 6, 5};
    int ar_exp[9]   = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int first_done;

    n_checks = 0;
    n_fails  = 0;
    a_if.clear = 0; a_if.load = 0; a_if.load_value = 0; a_if.count_enable = 0;
    b_if.clear = 0; b_if.load = 0; b_if.load_value = 0; b_if.count_enable = 0;

    // reset dominates a simultaneous load
    n_reset = 0;
    a_if.load = 1; a_if.load_value = 4'd5; a_if.count_enable = 1;
    step(); step();
    check_a("reset", 0, 1, 0, 0, 0);
    check("reset.b_count", b_if.count_out, 0);

    // basic count 3,2,1,0
    n_reset = 1;
    a_if.load_value = 4'd3;
    step();
    check_a("load3", 3, 0, 0, 1, 0);
    a_if.load = 0;
    step(); check_a("basic2", 2, 0, 0, 1, 0);
    step(); check_a("basic1", 1, 0, 0, 1, 0);
    step(); check_a("basic0", 0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_a($sformatf("stay0_%0d", i), 0, 1, 0, 0, 1);
    end

    // hold while enable low
    a_if.load = 1; a_if.load_value = 4'd7;
    step();
    check_a("load7", 7, 0, 0, 1, 0);
    a_if.load = 0;
    for (int i = 0; i < 4; i++) begin
      a_if.count_enable = hold_en[i][0];
      step();
      check_a($sformatf("hold_%0d", i), hold_exp[i], 0, 0, 1, 0);
    end

    // load wins over expiry
    a_if.load = 1; a_if.load_value = 4'd2; a_if.count_enable = 1;
    step();
    a_if.load = 0;
    step();
    check("prio.at1", a_if.count_out, 1);
    a_if.load = 1; a_if.load_value = 4'd5;
    step();
    check_a("prio.load", 5, 0, 0, 1, 0);

    // clear wins over load
    a_if.load_value = 4'd1;
    step();
    check("prio.at1b", a_if.count_out, 1);
    a_if.clear = 1; a_if.load_value = 4'd5;
    step();
    check_a("prio.clear", 0, 1, 0, 0, 0);
    a_if.clear = 0;

    // load of zero goes idle with no done
    a_if.load_value = 4'd0;
    step();
    check_a("load0", 0, 1, 0, 0, 0);
    a_if.load = 0;
    step();
    check_a("load0.en", 0, 1, 0, 0, 0);

    // full-scale load expires after exactly 15 enabled edges
    a_if.load = 1; a_if.load_value = 4'd15;
    step();
    check_a("load15", 15, 0, 0, 1, 0);
    a_if.load = 0;
    first_done = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (a_if.done && first_done < 0) first_done = i;
    end
    check("load15.done_edge", first_done, 15);
    check("load15.expired", a_if.expired, 1);

    // reset mid-count
    a_if.load = 1; a_if.load_value = 4'd9; a_if.count_enable = 0;
    step();
    a_if.load = 0;
    check("mid.at9", a_if.count_out, 9);
    n_reset = 0;
    step();
    check_a("mid.reset", 0, 1, 0, 0, 0);

    // reset drops a pending expiry
    n_reset = 1;
    a_if.load = 1; a_if.load_value = 4'd1;
    step();
    a_if.load = 0; a_if.count_enable = 1; n_reset = 0;
    step();
    check_a("pend.reset", 0, 1, 0, 0, 0);
    n_reset = 1;
    a_if.count_enable = 0;

    // auto-reload periodic tick
    b_if.load = 1; b_if.load_value = 4'd3; b_if.count_enable = 1;
    step();
    check("ar.load", b_if.count_out, 3);
    b_if.load = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("ar.count_%0d", k), b_if.count_out, ar_exp[k-1]);
      check($sformatf("ar.done_%0d", k), b_if.done, (k % 3 == 0) ? 1 : 0);
      check($sformatf("ar.expired_%0d", k), b_if.expired, 0);
      check($sformatf("ar.zero_%0d", k), b_if.zero_flag, 0);
    end
    check("ar.busy", b_if.busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
